// File: rtl/config_loader.sv
// Serial configuration-chain loader: serialises a valid/ready byte stream MSB-first onto config_in
// using a divided config_clk strobe. Optional readback CRC enabled by CFG_LOADER_READBACK_EN.
module config_loader #(
  parameter int CHAIN_LEN = 25,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       config_in,
  output logic       config_clk,
  output logic       config_en,
  input  logic       config_out
`ifdef CFG_LOADER_READBACK_EN
  ,
  output logic [15:0] rb_crc
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT_LO  = 3'd2,
    SHIFT_HI  = 3'd3,
    FINISH    = 3'd4
  } state_t;

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]     LEN      = 16'(CHAIN_LEN);

  state_t           state_r, state_s;
  logic [7:0]       shift_r, shift_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [15:0]      bit_cnt_r, bit_cnt_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             div_last_s;
  logic             config_in_s;

  assign div_last_s = (div_r == DIV_LAST);

  // Next-state, datapath and next config_in decode
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_idx_s   = bit_idx_r;
    bit_cnt_s   = bit_cnt_r;
    div_s       = div_r;
    config_in_s = config_in;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = WAIT_BYTE;
          bit_cnt_s = 16'd0;
          div_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_BYTE: begin
        if (in_valid && in_ready) begin
          shift_s   = in_data;
          bit_idx_s = 3'd7;
          div_s     = '0;
          state_s   = SHIFT_LO;
        end else begin
          state_s = WAIT_BYTE;
        end
      end
      SHIFT_LO: begin
        if (div_last_s) begin
          div_s   = '0;
          state_s = SHIFT_HI;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last_s) begin
          div_s     = '0;
          bit_cnt_s = bit_cnt_r + 16'd1;
          if (bit_cnt_s == LEN) begin
            state_s = FINISH;
          end else if (bit_idx_r != 3'd0) begin
            bit_idx_s = bit_idx_r - 3'd1;
            shift_s   = {shift_r[6:0], 1'b0};
            state_s   = SHIFT_LO;
          end else begin
            state_s = WAIT_BYTE;
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Data only moves on entry to the low phase, so it is settled a full half-period before the rise
    if (state_s == SHIFT_LO) begin
      config_in_s = shift_s[7];
    end else if ((state_s == IDLE) || (state_s == FINISH)) begin
      config_in_s = 1'b0;
    end else begin
      config_in_s = config_in;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
      bit_cnt_r  <= 16'd0;
      div_r      <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      config_in  <= 1'b0;
      config_clk <= 1'b0;
      config_en  <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      bit_cnt_r  <= bit_cnt_s;
      div_r      <= div_s;
      in_ready   <= (state_s == WAIT_BYTE);
      busy       <= (state_s != IDLE);
      done       <= (state_s == FINISH);
      config_in  <= config_in_s;
      config_clk <= (state_s == SHIFT_HI);
      config_en  <= (state_s == WAIT_BYTE) || (state_s == SHIFT_LO) || (state_s == SHIFT_HI);
    end
  end

`ifdef CFG_LOADER_READBACK_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ bit_in) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc_r;

  // Readback CRC: config_out is sampled just before each config_clk rise
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= 16'hFFFF;
    end else if ((state_r == IDLE) && start) begin
      crc_r <= 16'hFFFF;
    end else if ((state_r == SHIFT_LO) && div_last_s) begin
      crc_r <= crc16_step(crc_r, config_out);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign rb_crc = crc_r;
`else
  logic unused_config_out_s;
  assign unused_config_out_s = config_out;
`endif

endmodule
